// File: rtl/ls_bank_ctrl.sv
// Write-port controller for a load/store register bank: round-robin write arbitration and bank clear.
// Optional feature: define LS_BANK_CTRL_LOCK_EN to add the per-requester lock input.
module ls_bank_ctrl #(
    parameter int unsigned n  = 4,
    parameter int unsigned AW = 2
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [3:0]           req,
    input  logic [4*AW-1:0]      addr,
    input  logic [4*n-1:0]       wdata,
    input  logic                 bank_clr_req,
`ifdef LS_BANK_CTRL_LOCK_EN
    input  logic [3:0]           lock,
`endif
    output logic [3:0]           gnt,
    output logic [(1<<AW)-1:0]   reg_c,
    output logic                 reg_clr,
    output logic [n-1:0]         reg_in,
    output logic                 busy
);

    localparam int unsigned NREG = 1 << AW;

    typedef enum logic [1:0] {StIdle, StWrite, StClear} state_e;

    state_e            state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [3:0]        gnt_q, gnt_d;
    logic [NREG-1:0]   reg_c_q, reg_c_d;
    logic              reg_clr_q, reg_clr_d;
    logic [n-1:0]      reg_in_q, reg_in_d;
    logic              busy_q, busy_d;

    logic              win_found;
    logic [1:0]        win;
    logic [1:0]        cand;
    logic              ld_en;
    logic [1:0]        ld_sel;
    logic [AW-1:0]     ld_addr;

`ifdef LS_BANK_CTRL_LOCK_EN
    logic [1:0]        win_q;
`endif

    // First requester at or after ptr, wrapping modulo 4.
    always_comb begin
        win_found = 1'b0;
        win       = ptr_q;
        cand      = '0;
        for (int i = 0; i < 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win       = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = '0;
        reg_c_d   = '0;
        reg_clr_d = 1'b1;
        reg_in_d  = '0;
        ld_en     = 1'b0;
        ld_sel    = win;
        case (state_q)
            StIdle: begin
                if (bank_clr_req) begin
                    state_d   = StClear;
                    reg_clr_d = 1'b0;
                end else if (win_found) begin
                    state_d = StWrite;
                    ld_en   = 1'b1;
                    ld_sel  = win;
                    ptr_d   = win + 2'd1;
                end
            end
            StWrite: begin
                state_d = StIdle;
`ifdef LS_BANK_CTRL_LOCK_EN
                // A locked winner keeps the bus for another write cycle.
                if (req[win_q] && lock[win_q]) begin
                    state_d = StWrite;
                    ld_en   = 1'b1;
                    ld_sel  = win_q;
                end
`endif
            end
            StClear: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        ld_addr = addr[int'(ld_sel)*AW +: AW];
        if (ld_en) begin
            gnt_d[ld_sel]   = 1'b1;
            reg_c_d[ld_addr] = 1'b1;
            reg_in_d        = wdata[int'(ld_sel)*n +: n];
        end
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            gnt_q     <= '0;
            reg_c_q   <= '0;
            reg_clr_q <= 1'b1;
            reg_in_q  <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            reg_c_q   <= reg_c_d;
            reg_clr_q <= reg_clr_d;
            reg_in_q  <= reg_in_d;
            busy_q    <= busy_d;
        end
    end

`ifdef LS_BANK_CTRL_LOCK_EN
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            win_q <= '0;
        end else if (ld_en) begin
            win_q <= ld_sel;
        end
    end
`endif

    assign gnt     = gnt_q;
    assign reg_c   = reg_c_q;
    assign reg_clr = reg_clr_q;
    assign reg_in  = reg_in_q;
    assign busy    = busy_q;

endmodule
